jb_ul_dfe_p2s_int_delay: RTL and testbench
==========================================

// Module: jb_ul_dfe_p2s_int_delay
// PURPOSE
//  UL counterpart of the DL time-delay/S2P path: takes one parallel sample set per antenna (all antennas in one beat),
//  applies a per-antenna integer delay in frames, then serialises the set onto an AXI4-stream master.
//  Sits between the per-antenna UL NCO/decimation outputs and the UL TDM carrier stream; tuser = antenna index.
// PARAMETERS
//  N_ANTENNAS  4   antennas per frame; tuser width = $clog2(N_ANTENNAS)
//  PRECISION   16  I/Q component width; sample = {Q,I}, 2*PRECISION bits
//  DLY_AW      7   delay-line address width; depth 2**DLY_AW frames, max delay 2**DLY_AW-1
// PORTS
//  clk_4x          in   1                   491.52 MHz; sole clock
//  reset_4x        in   1                   async, active-high reset
//  tvalid_in       in   N_ANTENNAS          per-antenna valid; frame accepted when any bit set
//  tdata_in        in   [N_ANTENNAS][2P]    per-antenna sample {Q,I}
//  int_delay       in   [N_ANTENNAS][DLY_AW] requested integer delay (frames, unsigned)
//  delay_update    in   1                   1-cycle pulse: latch int_delay
//  IFP_dfe_out     jb_axi4_stream_if.master tdata 2P, tuser clog2(N), tvalid, tlast; tready from slave
//  ovf_sticky      out  1                   set on dropped frame; cleared by reset only
// BEHAVIOUR
//  Reset: tvalid/tlast/tuser/tdata=0, ovf_sticky=0, wr_ptr=0, fill_cnt=0, dly_keep=0, FSM=IDLE, pending empty.
//   Delay RAM not reset.
//  Delay update: delay_update latches int_delay into dly_pend; dly_pend copied to dly_keep on next accepted frame
//   (frame-aligned, all antennas switch together). Pulse on same cycle as a frame: that frame uses old delay.
//  Write: accepted frame writes tdata_in[a] (0 where tvalid_in[a]=0) at wr_ptr in every antenna RAM; wr_ptr++ wraps
//   at 2**DLY_AW. fill_cnt increments, saturating at 2**DLY_AW-1.
//  Read: rd_addr[a] = wr_ptr - dly_keep[a] (mod 2**DLY_AW), same cycle as write. Write-first: delay 0 returns current sample.
//   If dly_keep[a] > fill_cnt, sample forced to 0 (no stale RAM data after reset).
//  Read data registered (1 cycle) into the pending frame register; pending_vld set.
//  FSM IDLE: pending_vld -> load shift reg, pending_vld clr, SEND, beat idx=0.
//  FSM SEND: tvalid=1, tuser=idx, tdata=sample[idx], tlast=(idx==N-1). Advance only on tvalid&&tready.
//   Last handshake -> IDLE, or directly next SEND if pending_vld (back-to-back, no bubble).
//  AXI rules: tdata/tuser/tlast stable while tvalid&&!tready; tvalid never dropped without handshake.
//  Latency: frame at cycle T, tready=1, delay 0 -> antenna 0 beat at T+2, antenna N-1 at T+1+N.
//  Overflow: new read result arrives while pending_vld still set -> new frame dropped, pending kept,
//   ovf_sticky=1. Write side never stalls: RAM/wr_ptr/fill_cnt advance regardless of tready.
//  Sustained rate: one frame per N cycles with tready=1 never overflows.
//  Reset mid-frame: async clear, partial frame discarded, no tlast emitted.
// CONFIGURATION
//  JB_UL_P2S_OVF_CNT_EN defined: adds out [15:0] ovf_cnt, +1 per dropped frame, saturates at 16'hFFFF, reset 0.
//   Absent: no port, no counter; ovf_sticky present in both builds.
// TESTING
//  1 reset, dly=0, frames {A0..A3} every 4 cycles, tready=1 -> beats tuser 0,1,2,3 at T+2..T+5, tlast on tuser 3 only.
//  2 dly={0,1,2,3}, ramp data k per frame -> frame 5 carries ant0=5, ant1=4, ant2=3, ant3=2; frame 1: ant2=0, ant3=0.
//  3 delay_update to dly=10 on ant1 mid-stream -> change on next frame boundary only; first 10 new-delay outputs
//    replay stored history, no zero gap (fill_cnt > 10).
//  4 tready=0 for 12 cycles, frames every 4 cycles -> beat held stable, 1 frame pending, later frames dropped,
//    ovf_sticky=1; with JB_UL_P2S_OVF_CNT_EN ovf_cnt = number of dropped frames.
//  5 dly=127, 200 frames -> output zero for frames 0..126, frame 127 outputs frame-0 data (wrap correct).
//  6 async reset_4x during beat 2 -> tvalid=0 same cycle; next frame restarts at tuser 0, fill zeros apply.

Source files
------------

// File: rtl/jb_ul_dfe_p2s_int_delay.sv
// UL per-antenna integer frame delay followed by parallel-to-serial AXI4-stream output.
// Optional JB_UL_P2S_OVF_CNT_EN adds a saturating 16-bit dropped-frame counter output.
module jb_ul_dfe_p2s_int_delay #(
  parameter int unsigned N_ANTENNAS = 4,
  parameter int unsigned PRECISION  = 16,
  parameter int unsigned DLY_AW     = 7,
  localparam int unsigned SW        = 2 * PRECISION,
  localparam int unsigned UW        = (N_ANTENNAS > 1) ? $clog2(N_ANTENNAS) : 1,
  localparam int unsigned DEPTH     = 2 ** DLY_AW
) (
  input  logic                                  clk_4x,
  input  logic                                  reset_4x,
  input  logic [N_ANTENNAS-1:0]                 tvalid_in,
  input  logic [N_ANTENNAS-1:0][SW-1:0]         tdata_in,
  input  logic [N_ANTENNAS-1:0][DLY_AW-1:0]     int_delay,
  input  logic                                  delay_update,
  output logic [SW-1:0]                         IFP_dfe_out_tdata,
  output logic [UW-1:0]                         IFP_dfe_out_tuser,
  output logic                                  IFP_dfe_out_tvalid,
  output logic                                  IFP_dfe_out_tlast,
  input  logic                                  IFP_dfe_out_tready,
`ifdef JB_UL_P2S_OVF_CNT_EN
  output logic [15:0]                           ovf_cnt,
`endif
  output logic                                  ovf_sticky
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  logic                              accept;
  logic [N_ANTENNAS-1:0][DLY_AW-1:0] dly_pend_q, dly_keep_q, dly_eff;
  logic                              dly_flag_q;
  logic [DLY_AW-1:0]                 wr_ptr_q, fill_q;
  logic [N_ANTENNAS-1:0][SW-1:0]     wdata, rd_sample;
  logic [N_ANTENNAS-1:0][SW-1:0]     pending_q;
  logic                              pend_vld_q;
  logic [SW-1:0]                     ram [N_ANTENNAS][DEPTH];

  state_e                            state_q, state_d;
  logic [UW-1:0]                     idx_q, idx_d;
  logic [N_ANTENNAS-1:0][SW-1:0]     sreg_q, sreg_d;
  logic                              hs, last_hs, take;

  assign accept = |tvalid_in;

  // A latched-but-unapplied update takes effect on the first frame after the pulse.
  assign dly_eff = dly_flag_q ? dly_pend_q : dly_keep_q;

  always_comb begin
    wdata     = '0;
    rd_sample = '0;
    for (int unsigned a = 0; a < N_ANTENNAS; a++) begin
      wdata[a] = tvalid_in[a] ? tdata_in[a] : '0;
      if (dly_eff[a] > fill_q) begin
        rd_sample[a] = '0;
      end else if (dly_eff[a] == '0) begin
        rd_sample[a] = wdata[a];
      end else begin
        rd_sample[a] = ram[a][wr_ptr_q - dly_eff[a]];
      end
    end
  end

  always_ff @(posedge clk_4x) begin
    if (accept) begin
      for (int unsigned a = 0; a < N_ANTENNAS; a++) begin
        ram[a][wr_ptr_q] <= wdata[a];
      end
    end
  end

  always_ff @(posedge clk_4x or posedge reset_4x) begin
    if (reset_4x) begin
      dly_pend_q <= '0;
      dly_keep_q <= '0;
      dly_flag_q <= 1'b0;
      wr_ptr_q   <= '0;
      fill_q     <= '0;
    end else begin
      if (delay_update) begin
        dly_pend_q <= int_delay;
      end
      if (delay_update) begin
        dly_flag_q <= 1'b1;
      end else if (accept) begin
        dly_flag_q <= 1'b0;
      end
      if (accept) begin
        if (dly_flag_q) begin
          dly_keep_q <= dly_pend_q;
        end
        wr_ptr_q <= wr_ptr_q + 1'b1;
        if (fill_q != DLY_AW'(DEPTH - 1)) begin
          fill_q <= fill_q + 1'b1;
        end
      end
    end
  end

  assign hs      = (state_q == StSend) && IFP_dfe_out_tready;
  assign last_hs = hs && (idx_q == UW'(N_ANTENNAS - 1));
  assign take    = pend_vld_q && ((state_q == StIdle) || last_hs);

  always_ff @(posedge clk_4x or posedge reset_4x) begin
    if (reset_4x) begin
      pending_q  <= '0;
      pend_vld_q <= 1'b0;
      ovf_sticky <= 1'b0;
`ifdef JB_UL_P2S_OVF_CNT_EN
      ovf_cnt    <= '0;
`endif
    end else if (accept) begin
      if (pend_vld_q && !take) begin
        // Pending frame still waiting for the serialiser: drop the newcomer.
        ovf_sticky <= 1'b1;
`ifdef JB_UL_P2S_OVF_CNT_EN
        if (ovf_cnt != 16'hFFFF) begin
          ovf_cnt <= ovf_cnt + 16'd1;
        end
`endif
      end else begin
        pending_q  <= rd_sample;
        pend_vld_q <= 1'b1;
      end
    end else if (take) begin
      pend_vld_q <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sreg_d  = sreg_q;
    unique case (state_q)
      StIdle: begin
        if (pend_vld_q) begin
          state_d = StSend;
          idx_d   = '0;
          sreg_d  = pending_q;
        end
      end
      StSend: begin
        if (last_hs) begin
          idx_d = '0;
          if (pend_vld_q) begin
            sreg_d = pending_q;
          end else begin
            state_d = StIdle;
          end
        end else if (hs) begin
          idx_d  = idx_q + 1'b1;
          sreg_d = sreg_q >> SW;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_4x or posedge reset_4x) begin
    if (reset_4x) begin
      state_q <= StIdle;
      idx_q   <= '0;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sreg_q  <= sreg_d;
    end
  end

  assign IFP_dfe_out_tvalid = (state_q == StSend);
  assign IFP_dfe_out_tdata  = IFP_dfe_out_tvalid ? sreg_q[0] : '0;
  assign IFP_dfe_out_tuser  = IFP_dfe_out_tvalid ? idx_q : '0;
  assign IFP_dfe_out_tlast  = IFP_dfe_out_tvalid && (idx_q == UW'(N_ANTENNAS - 1));

endmodule

// File: tb/tb_jb_ul_dfe_p2s_int_delay.sv
// Directed scoreboard bench for jb_ul_dfe_p2s_int_delay (default parameters).
module tb_jb_ul_dfe_p2s_int_delay;
  localparam int N  = 4;
  localparam int P  = 16;
  localparam int AW = 7;

  logic                     clk_4x = 1'b0;
  logic                     reset_4x = 1'b1;
  logic [N-1:0]             tvalid_in = '0;
  logic [N-1:0][2*P-1:0]    tdata_in = '0;
  logic [N-1:0][AW-1:0]     int_delay = '0;
  logic                     delay_update = 1'b0;
  logic [2*P-1:0]           tdata;
  logic [1:0]               tuser;
  logic                     tvalid, tlast;
  logic                     tready = 1'b1;
  logic                     ovf_sticky;
`ifdef JB_UL_P2S_OVF_CNT_EN
  logic [15:0]              ovf_cnt;
`endif

  always #5 clk_4x = ~clk_4x;

  jb_ul_dfe_p2s_int_delay dut (
    .clk_4x             (clk_4x),
    .reset_4x           (reset_4x),
    .tvalid_in          (tvalid_in),
    .tdata_in           (tdata_in),
    .int_delay          (int_delay),
    .delay_update       (delay_update),
    .IFP_dfe_out_tdata  (tdata),
    .IFP_dfe_out_tuser  (tuser),
    .IFP_dfe_out_tvalid (tvalid),
    .IFP_dfe_out_tlast  (tlast),
    .IFP_dfe_out_tready (tready),
`ifdef JB_UL_P2S_OVF_CNT_EN
    .ovf_cnt            (ovf_cnt),
`endif
    .ovf_sticky         (ovf_sticky)
  );

  typedef struct packed {
    logic [1:0]  user;
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t                q[$];
  logic [31:0]          hist [0:511][0:N-1];
  int                   k;
  logic [N-1:0][AW-1:0] keep_m, pend_m;
  bit                   flag_m;
  int                   total = 0;
  int                   bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk_4x) begin
    if (reset_4x === 1'b0 && tvalid === 1'b1 && tready === 1'b1) begin
      if (q.size() == 0) begin
        chk("beat_unexpected", 64'(q.size()), 64'd1);
      end else begin
        beat_t e;
        e = q.pop_front();
        chk("beat_tuser", 64'(tuser), 64'(e.user));
        chk("beat_tdata", 64'(tdata), 64'(e.data));
        chk("beat_tlast", 64'(tlast), 64'(e.last));
      end
    end
  end

  function automatic logic [N-1:0][31:0] ramp(input int v);
    logic [N-1:0][31:0] r;
    for (int a = 0; a < N; a++) r[a] = 32'(v);
    return r;
  endfunction

  // Drives one cycle of frame/update stimulus and pushes the model's expected beats.
  task automatic send(input logic [N-1:0][31:0] d, input logic [N-1:0] v, input bit pulse,
                      input logic [N-1:0][AW-1:0] dly, input bit drop, input int gap);
    logic [N-1:0][AW-1:0] eff;
    logic [31:0]          e;
    tvalid_in = v;
    tdata_in  = d;
    if (pulse) begin
      delay_update = 1'b1;
      int_delay    = dly;
    end
    if (v != '0) begin
      eff = flag_m ? pend_m : keep_m;
      if (flag_m) keep_m = pend_m;
      flag_m = 1'b0;
      for (int a = 0; a < N; a++) hist[k][a] = v[a] ? d[a] : 32'd0;
      for (int a = 0; a < N; a++) begin
        e = (int'(eff[a]) <= k) ? hist[k - int'(eff[a])][a] : 32'd0;
        if (!drop) q.push_back('{user: 2'(a), data: e, last: (a == N - 1)});
      end
      k++;
    end
    if (pulse) begin
      pend_m = dly;
      flag_m = 1'b1;
    end
    @(posedge clk_4x); #1;
    tvalid_in    = '0;
    tdata_in     = '0;
    delay_update = 1'b0;
    repeat (gap - 1) begin
      @(posedge clk_4x); #1;
    end
  endtask

  task automatic do_reset();
    reset_4x = 1'b1;
    q.delete();
    k      = 0;
    keep_m = '0;
    pend_m = '0;
    flag_m = 1'b0;
    @(posedge clk_4x); #1;
    reset_4x = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_4x); #1;
    end
  endtask

  logic [N-1:0][AW-1:0] dly_v;
  logic [N-1:0][31:0]   fr;
  logic [31:0]          a0;

  initial begin
    idle(2);
    do_reset();
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tlast", 64'(tlast), 64'd0);
    chk("rst_tuser", 64'(tuser), 64'd0);
    chk("rst_tdata", 64'(tdata), 64'd0);
    chk("rst_ovf", 64'(ovf_sticky), 64'd0);

    // 1: delay 0, distinct per-antenna samples, latency check on first frame
    for (int a = 0; a < N; a++) fr[a] = 32'hA000_00A0 + 32'(a);
    send(fr, '1, 1'b0, '0, 1'b0, 1);
    idle(1);
    chk("lat_first_tvalid", 64'(tvalid), 64'd1);
    chk("lat_first_tuser", 64'(tuser), 64'd0);
    chk("lat_first_tlast", 64'(tlast), 64'd0);
    idle(3);
    chk("lat_last_tuser", 64'(tuser), 64'd3);
    chk("lat_last_tlast", 64'(tlast), 64'd1);
    for (int f = 1; f < 4; f++) begin
      for (int a = 0; a < N; a++) fr[a] = 32'hA000_00A0 + 32'(16 * f + a);
      send(fr, '1, 1'b0, '0, 1'b0, 4);
    end
    idle(10);

    // 2: delays {0,1,2,3} with ramp data; stale RAM from test 1 must read as zero
    do_reset();
    for (int a = 0; a < N; a++) dly_v[a] = AW'(a);
    send('0, '0, 1'b1, dly_v, 1'b0, 1);
    for (int f = 0; f < 8; f++) send(ramp(k), '1, 1'b0, '0, 1'b0, 4);

    // 3: ant1 -> 10 pulsed together with a frame; only later frames see it
    dly_v[1] = AW'(10);
    for (int f = 0; f < 22; f++) send(ramp(k), '1, (f == 4), dly_v, 1'b0, 4);
    idle(10);
    chk("pre_stall_ovf", 64'(ovf_sticky), 64'd0);

    // 4: tready low 12 cycles; A held, B pending, C and D dropped, E accepted
    tready = 1'b0;
    a0 = 32'(k);
    send(ramp(k), '1, 1'b0, '0, 1'b0, 4);
    chk("stall_a_tvalid", 64'(tvalid), 64'd1);
    chk("stall_a_tdata", 64'(tdata), 64'(a0));
    send(ramp(k), '1, 1'b0, '0, 1'b0, 4);
    chk("stall_b_tuser", 64'(tuser), 64'd0);
    chk("stall_b_tdata", 64'(tdata), 64'(a0));
    send(ramp(k), '1, 1'b0, '0, 1'b1, 4);
    chk("stall_c_tvalid", 64'(tvalid), 64'd1);
    chk("stall_c_tdata", 64'(tdata), 64'(a0));
    chk("stall_c_ovf", 64'(ovf_sticky), 64'd1);
    tready = 1'b1;
    send(ramp(k), '1, 1'b0, '0, 1'b1, 4);
    send(ramp(k), '1, 1'b0, '0, 1'b0, 4);
    idle(12);
    chk("stall_ovf_sticky", 64'(ovf_sticky), 64'd1);
`ifdef JB_UL_P2S_OVF_CNT_EN
    chk("stall_ovf_cnt", 64'(ovf_cnt), 64'd2);
`endif

    // 5: max delay, 200 frames; zeros until frame 127 replays frame 0
    do_reset();
    chk("rst2_ovf", 64'(ovf_sticky), 64'd0);
    send('0, '0, 1'b1, {N{AW'(127)}}, 1'b0, 1);
    for (int f = 0; f < 200; f++) begin
      for (int a = 0; a < N; a++) fr[a] = 32'h5000_0000 | 32'(a << 12) | 32'(f + 1);
      send(fr, '1, 1'b0, '0, 1'b0, 4);
    end
    idle(10);

    // 6: async reset during beat 2, then fill zeros after restart
    do_reset();
    for (int a = 0; a < N; a++) fr[a] = 32'h6000_0000 + 32'(a);
    send(fr, '1, 1'b0, '0, 1'b0, 1);
    idle(3);
    chk("mid_beat2_tuser", 64'(tuser), 64'd2);
    reset_4x = 1'b1;
    #1;
    chk("mid_rst_tvalid", 64'(tvalid), 64'd0);
    chk("mid_rst_tlast", 64'(tlast), 64'd0);
    q.delete();
    k      = 0;
    keep_m = '0;
    pend_m = '0;
    flag_m = 1'b0;
    @(posedge clk_4x); #1;
    reset_4x = 1'b0;
    for (int a = 0; a < N; a++) dly_v[a] = AW'(a);
    send('0, '0, 1'b1, dly_v, 1'b0, 1);
    for (int f = 0; f < 3; f++) begin
      for (int a = 0; a < N; a++) fr[a] = 32'h7000_0000 + 32'(16 * f + a);
      send(fr, '1, 1'b0, '0, 1'b0, 4);
    end
    idle(12);

    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
